wb_regfile: RTL and testbench

//  Write-back stage and integer register file; the consumer end of the MEM/WB pipeline register.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/wb_result_mux.sv | 32 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: WB control bit positions, RegSrc encodings and widths.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam int WB_VALID     = 4;
   localparam int WB_REGWRITE  = 3;
   localparam int WB_MEMTOREG  = 2;
   localparam int WB_REGSRC_HI = 1;
   localparam int WB_REGSRC_LO = 0;

   // Encodings 2'b10/2'b11 are reserved and fall back to the ALU result.
   typedef enum logic [1:0] {
      REGSRC_ALU  = 2'b00,
      REGSRC_LINK = 2'b01,
      REGSRC_RSV2 = 2'b10,
      REGSRC_RSV3 = 2'b11
   } regSrc_e;

   function automatic logic [XLEN-1:0] linkAddr(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Combinational write-back value select between load data, ALU result and PC+4 link.
module wb_result_mux
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            i_memtoReg,
   input  logic [1:0]      i_regSrc,
   input  logic [XLEN-1:0] i_readData,
   input  logic [XLEN-1:0] i_aluResult,
   input  logic [XLEN-1:0] i_pc,
   output logic [XLEN-1:0] o_result
);

   regSrc_e w_regSrc;

   assign w_regSrc = regSrc_e'(i_regSrc);

   // Load data wins over RegSrc; link addresses wrap modulo 2^XLEN.
   always_comb begin
      o_result = i_aluResult;
      if (i_memtoReg) begin
         o_result = i_readData;
      end else begin
         unique case (w_regSrc)
            REGSRC_LINK: o_result = i_pc + XLEN'(4);
            default:     o_result = i_aluResult;
         endcase
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus integer register file with two async read ports and a retire counter.
// Optional same-cycle write-before-read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile
   import riscv_pkg::*;
#(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [4:0]       WB_control,
   input  logic [4:0]       RegDst,
   input  logic [XLEN-1:0]  ReadData,
   input  logic [XLEN-1:0]  ALUResult,
   input  logic [XLEN-1:0]  PC,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic             wb_wr_en,
   output logic [4:0]       wb_wr_addr,
   output logic [XLEN-1:0]  wb_wr_data,
   output logic [CNT_W-1:0] retire_count
);

   logic [XLEN-1:0]  r_regs [NREG];
   logic [CNT_W-1:0] r_retireCount;
   logic [XLEN-1:0]  w_wrData;
   logic             w_wrEn;
   logic             w_valid;
   logic [XLEN-1:0]  w_rs1Reg;
   logic [XLEN-1:0]  w_rs2Reg;

   wb_result_mux #(.XLEN(XLEN)) u_resultMux (
      .i_memtoReg  (WB_control[WB_MEMTOREG]),
      .i_regSrc    (WB_control[WB_REGSRC_HI:WB_REGSRC_LO]),
      .i_readData  (ReadData),
      .i_aluResult (ALUResult),
      .i_pc        (PC),
      .o_result    (w_wrData)
   );

   assign w_valid = WB_control[WB_VALID];
   assign w_wrEn  = w_valid & WB_control[WB_REGWRITE] & (RegDst != 5'd0);

   assign wb_wr_en     = w_wrEn;
   assign wb_wr_addr   = RegDst;
   assign wb_wr_data   = w_wrData;
   assign retire_count = r_retireCount;

   // Entry 0 is cleared by reset and never targeted by a write, so it stays zero.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wrEn) begin
         r_regs[RegDst] <= w_wrData;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_retireCount <= '0;
      end else if (w_valid) begin
         r_retireCount <= r_retireCount + CNT_W'(1);
      end
   end

   assign w_rs1Reg = (rs1_addr == 5'd0) ? '0 : r_regs[rs1_addr];
   assign w_rs2Reg = (rs2_addr == 5'd0) ? '0 : r_regs[rs2_addr];

`ifdef WB_BYPASS_EN
   assign rs1_data = (w_wrEn && (rs1_addr == RegDst)) ? w_wrData : w_rs1Reg;
   assign rs2_data = (w_wrEn && (rs2_addr == RegDst)) ? w_wrData : w_rs2Reg;
`else
   assign rs1_data = w_rs1Reg;
   assign rs2_data = w_rs2Reg;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a monitor compares them.
module tb_wb_regfile;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam int SEL_RS1   = 0;
   localparam int SEL_RS2   = 1;
   localparam int SEL_WREN  = 2;
   localparam int SEL_WADDR = 3;
   localparam int SEL_WDATA = 4;
   localparam int SEL_CNT   = 5;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } sbEntry_t;

   logic             clock;
   logic             resetN;
   logic [4:0]       wbControl;
   logic [4:0]       regDst;
   logic [XLEN-1:0]  readData;
   logic [XLEN-1:0]  aluResult;
   logic [XLEN-1:0]  pc;
   logic [4:0]       rs1Addr;
   logic [4:0]       rs2Addr;
   logic [XLEN-1:0]  rs1Data;
   logic [XLEN-1:0]  rs2Data;
   logic             wbWrEn;
   logic [4:0]       wbWrAddr;
   logic [XLEN-1:0]  wbWrData;
   logic [CNT_W-1:0] retireCount;

   sbEntry_t sbQ[$];
   event     checkEv;
   int       vecCount  = 0;
   int       missCount = 0;

   wb_regfile #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
      .CLK          (clock),
      .RESET        (resetN),
      .WB_control   (wbControl),
      .RegDst       (regDst),
      .ReadData     (readData),
      .ALUResult    (aluResult),
      .PC           (pc),
      .rs1_addr     (rs1Addr),
      .rs2_addr     (rs2Addr),
      .rs1_data     (rs1Data),
      .rs2_data     (rs2Data),
      .wb_wr_en     (wbWrEn),
      .wb_wr_addr   (wbWrAddr),
      .wb_wr_data   (wbWrData),
      .retire_count (retireCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] actualOf(input int sel);
      case (sel)
         SEL_RS1:   return rs1Data;
         SEL_RS2:   return rs2Data;
         SEL_WREN:  return {31'd0, wbWrEn};
         SEL_WADDR: return {27'd0, wbWrAddr};
         SEL_WDATA: return wbWrData;
         default:   return {28'd0, retireCount};
      endcase
   endfunction

   // Monitor: drains every queued expectation whenever stimulus signals a sample point.
   initial begin
      sbEntry_t    e;
      logic [31:0] act;
      forever begin
         @(checkEv);
         while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            act = actualOf(e.sel);
            vecCount++;
            if (act !== e.exp) begin
               missCount++;
               $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [4:0] ctrl, input logic [4:0] dst,
                                input logic [31:0] rd, input logic [31:0] alu,
                                input logic [31:0] pcVal);
      @(negedge clock);
      wbControl = ctrl;
      regDst    = dst;
      readData  = rd;
      aluResult = alu;
      pc        = pcVal;
      #1;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
      sbEntry_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sbQ.push_back(e);
   endtask

   task automatic sampleNow();
      ->checkEv;
      #0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetN  = 1'b0;
      rs1Addr = 5'd5;
      rs2Addr = 5'd0;
      wbControl = '0; regDst = '0; readData = '0; aluResult = '0; pc = '0;

      // A valid write held across edges while in reset must not commit.
      applyStimulus(5'b11000, 5'd5, 32'h0, 32'h1111, 32'h0);
      @(posedge clock);
      @(posedge clock);
      applyStimulus(5'b11000, 5'd5, 32'h0, 32'h1111, 32'h0);
      checkOutput("rst_x5", SEL_RS1, 32'h0);
      checkOutput("rst_cnt", SEL_CNT, 32'h0);
      checkOutput("rst_wren_tracks", SEL_WREN, 32'h1);
      sampleNow();

      @(negedge clock);
      wbControl = '0;
      resetN    = 1'b1;

      applyStimulus(5'b11000, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0);
      checkOutput("alu_wren", SEL_WREN, 32'h1);
      checkOutput("alu_waddr", SEL_WADDR, 32'h5);
      checkOutput("alu_wdata", SEL_WDATA, 32'hDEADBEEF);
      checkOutput("alu_pre_rs1", SEL_RS1, BYPASS ? 32'hDEADBEEF : 32'h0);
      sampleNow();

      rs2Addr = 5'd6;
      applyStimulus(5'b11100, 5'd6, 32'h1234, 32'h9999, 32'h0);
      checkOutput("alu_post_x5", SEL_RS1, 32'hDEADBEEF);
      checkOutput("alu_cnt", SEL_CNT, 32'h1);
      checkOutput("load_wdata", SEL_WDATA, 32'h1234);
      sampleNow();

      applyStimulus(5'b11001, 5'd7, 32'h1, 32'h2, 32'hFFFFFFFC);
      checkOutput("load_post_x6", SEL_RS2, 32'h1234);
      checkOutput("link_wrap_wdata", SEL_WDATA, 32'h0);
      sampleNow();

      rs1Addr = 5'd8;
      applyStimulus(5'b11001, 5'd8, 32'h1, 32'h2, 32'h00000100);
      checkOutput("link_wdata", SEL_WDATA, 32'h104);
      sampleNow();

      rs2Addr = 5'd10;
      applyStimulus(5'b11010, 5'd10, 32'h1, 32'hCAFE, 32'h0);
      checkOutput("link_post_x8", SEL_RS1, 32'h104);
      checkOutput("rsv_regsrc_wdata", SEL_WDATA, 32'hCAFE);
      sampleNow();

      rs1Addr = 5'd0;
      applyStimulus(5'b11000, 5'd0, 32'h0, 32'h55, 32'h0);
      checkOutput("rsv_post_x10", SEL_RS2, 32'hCAFE);
      checkOutput("x0_wren", SEL_WREN, 32'h0);
      checkOutput("cnt_before_x0", SEL_CNT, 32'h5);
      sampleNow();

      rs2Addr = 5'd5;
      applyStimulus(5'b00000, 5'd5, 32'h0, 32'h0, 32'h0);
      checkOutput("x0_reads_zero", SEL_RS1, 32'h0);
      checkOutput("x0_cnt", SEL_CNT, 32'h6);
      checkOutput("bubble_wren", SEL_WREN, 32'h0);
      sampleNow();

      applyStimulus(5'b01000, 5'd5, 32'h0, 32'h0, 32'h0);
      checkOutput("bubble_x5", SEL_RS2, 32'hDEADBEEF);
      checkOutput("bubble_cnt", SEL_CNT, 32'h6);
      checkOutput("novalid_wren", SEL_WREN, 32'h0);
      sampleNow();

      applyStimulus(5'b10000, 5'd5, 32'h0, 32'h0, 32'h0);
      checkOutput("novalid_x5", SEL_RS2, 32'hDEADBEEF);
      checkOutput("novalid_cnt", SEL_CNT, 32'h6);
      checkOutput("store_wren", SEL_WREN, 32'h0);
      sampleNow();

      // Eight more store-like retires take the 4-bit counter from 7 up to 15.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(5'b10000, 5'd5, 32'h0, 32'h0, 32'h0);
      end
      applyStimulus(5'b10000, 5'd5, 32'h0, 32'h0, 32'h0);
      checkOutput("cnt_max", SEL_CNT, 32'hF);
      checkOutput("store_x5", SEL_RS2, 32'hDEADBEEF);
      sampleNow();

      rs1Addr = 5'd9;
      rs2Addr = 5'd9;
      applyStimulus(5'b11000, 5'd9, 32'h0, 32'h1111, 32'h0);
      checkOutput("cnt_wrap", SEL_CNT, 32'h0);
      sampleNow();

      applyStimulus(5'b11000, 5'd9, 32'h0, 32'hA5A5, 32'h0);
      checkOutput("same_cycle_rs2", SEL_RS2, BYPASS ? 32'hA5A5 : 32'h1111);
      checkOutput("same_cycle_rs1", SEL_RS1, BYPASS ? 32'hA5A5 : 32'h1111);
      sampleNow();

      applyStimulus(5'b00000, 5'd9, 32'h0, 32'h0, 32'h0);
      checkOutput("after_edge_rs2", SEL_RS2, 32'hA5A5);
      checkOutput("after_edge_cnt", SEL_CNT, 32'h2);
      sampleNow();

      // Asynchronous mid-run reset, asserted between clock edges.
      rs1Addr = 5'd5;
      @(negedge clock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("midrst_x5", SEL_RS1, 32'h0);
      checkOutput("midrst_x9", SEL_RS2, 32'h0);
      checkOutput("midrst_cnt", SEL_CNT, 32'h0);
      sampleNow();

      @(negedge clock);
      resetN = 1'b1;
      #2;

      if (sbQ.size() != 0) begin
         missCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
